// File: rtl/regfile_wport_arb.sv
// Register-file write-port arbiter: a 2-entry FIFO for pipeline writeback (A)
// shares the port with a valid/ready multi-cycle unit (B). Define REGFILE_ARB_FWD_EN to add forwarding lookup ports.
module regfile_wport_arb #(
    parameter int WIDTH      = 32,
    parameter int R_WIDTH    = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               a_valid_i,
    input  logic [R_WIDTH-1:0] a_addr_i,
    input  logic [WIDTH-1:0]   a_data_i,
    output logic               a_full_o,
    input  logic               b_valid_i,
    input  logic [R_WIDTH-1:0] b_addr_i,
    input  logic [WIDTH-1:0]   b_data_i,
    output logic               b_ready_o,
    output logic               wr_en_o,
    output logic [R_WIDTH-1:0] wr_addr_o,
    output logic [WIDTH-1:0]   wr_data_o,
`ifdef REGFILE_ARB_FWD_EN
    input  logic [R_WIDTH-1:0] fwd_addr_i,
    output logic               fwd_hit_o,
    output logic [WIDTH-1:0]   fwd_data_o,
`endif
    output logic               ovf_o
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [R_WIDTH-1:0] fifo_addr_q [2];
    logic [WIDTH-1:0]   fifo_data_q [2];
    logic               wptr_q;
    logic               rptr_q;
    logic [1:0]         count_q;
    logic [1:0]         count_d;
    logic [3:0]         starve_q;
    logic [3:0]         starve_d;
    logic               ovf_q;
    logic               wr_en_q;
    logic               wr_en_d;
    logic [R_WIDTH-1:0] wr_addr_q;
    logic [R_WIDTH-1:0] wr_addr_d;
    logic [WIDTH-1:0]   wr_data_q;
    logic [WIDTH-1:0]   wr_data_d;

    logic a_push_req;
    logic b_req;
    logic b_zero;
    logic fifo_empty;
    logic fifo_full;
    logic grant_a;
    logic grant_b;
    logic push_ok;

    assign a_push_req = a_valid_i && (a_addr_i != '0);
    assign b_req      = b_valid_i && (b_addr_i != '0);
    assign b_zero     = b_valid_i && (b_addr_i == '0);
    assign fifo_empty = (count_q == 2'd0);
    assign fifo_full  = (count_q == 2'd2);

    // B wins only on an idle FIFO or once it has waited STARVE_MAX cycles.
    assign grant_b = b_req && (fifo_empty || (starve_q == STARVE_LIM));
    assign grant_a = !fifo_empty && !grant_b;
    assign push_ok = a_push_req && (!fifo_full || grant_a);

    assign b_ready_o = grant_b || b_zero;
    assign a_full_o  = fifo_full;
    assign ovf_o     = ovf_q;
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

    always_comb begin
        count_d = count_q;
        case ({push_ok, grant_a})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = 4'd0;
        if (b_req && !grant_b) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
        end
    end

    always_comb begin
        wr_en_d   = grant_a || grant_b;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (grant_b) begin
            wr_addr_d = b_addr_i;
            wr_data_d = b_data_i;
        end else if (grant_a) begin
            wr_addr_d = fifo_addr_q[rptr_q];
            wr_data_d = fifo_data_q[rptr_q];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fifo_addr_q[0] <= '0;
            fifo_addr_q[1] <= '0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
        end else if (push_ok) begin
            fifo_addr_q[wptr_q] <= a_addr_i;
            fifo_data_q[wptr_q] <= a_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            count_q   <= 2'd0;
            starve_q  <= 4'd0;
            ovf_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= ~wptr_q;
            end
            if (grant_a) begin
                rptr_q <= ~rptr_q;
            end
            if (a_push_req && !push_ok) begin
                ovf_q <= 1'b1;
            end
            count_q   <= count_d;
            starve_q  <= starve_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef REGFILE_ARB_FWD_EN
    logic newest;

    assign newest = ~wptr_q;

    // Youngest match wins: newest FIFO slot, then older slot, then output register.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        if (fwd_addr_i != '0) begin
            if (!fifo_empty && (fifo_addr_q[newest] == fwd_addr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = fifo_data_q[newest];
            end else if (fifo_full && (fifo_addr_q[rptr_q] == fwd_addr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = fifo_data_q[rptr_q];
            end else if (wr_en_q && (wr_addr_q == fwd_addr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = wr_data_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Self-checking bench for regfile_wport_arb: table-driven cycles with a
// scoreboard of expected write-port values, plus hand-written reset/forwarding sequences.
module tb_regfile_wport_arb;

    localparam int WIDTH      = 32;
    localparam int R_WIDTH    = 5;
    localparam int STARVE_MAX = 4;

    typedef struct {
        logic               av;
        logic [R_WIDTH-1:0] aa;
        logic [WIDTH-1:0]   ad;
        logic               bv;
        logic [R_WIDTH-1:0] ba;
        logic [WIDTH-1:0]   bd;
        logic               expReady;
        logic               expFull;
    } vec_t;

    typedef struct {
        logic               en;
        logic [R_WIDTH-1:0] addr;
        logic [WIDTH-1:0]   data;
    } wr_t;

    logic               clk_i;
    logic               rst_n_i;
    logic               a_valid_i;
    logic [R_WIDTH-1:0] a_addr_i;
    logic [WIDTH-1:0]   a_data_i;
    logic               a_full_o;
    logic               b_valid_i;
    logic [R_WIDTH-1:0] b_addr_i;
    logic [WIDTH-1:0]   b_data_i;
    logic               b_ready_o;
    logic               wr_en_o;
    logic [R_WIDTH-1:0] wr_addr_o;
    logic [WIDTH-1:0]   wr_data_o;
    logic               ovf_o;
`ifdef REGFILE_ARB_FWD_EN
    logic [R_WIDTH-1:0] fwd_addr_i;
    logic               fwd_hit_o;
    logic [WIDTH-1:0]   fwd_data_o;
`endif

    int checks = 0;
    int errors = 0;

    vec_t               vecs[$];
    wr_t                sb[$];
    logic [R_WIDTH-1:0] mqAddr[$];
    logic [WIDTH-1:0]   mqData[$];
    int                 mStarve = 0;
    logic               mOvf = 1'b0;
    logic [R_WIDTH-1:0] mLastAddr = '0;
    logic [WIDTH-1:0]   mLastData = '0;

    regfile_wport_arb #(
        .WIDTH(WIDTH), .R_WIDTH(R_WIDTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .a_valid_i(a_valid_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i),
        .a_full_o(a_full_o),
        .b_valid_i(b_valid_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i),
        .b_ready_o(b_ready_o),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
`ifdef REGFILE_ARB_FWD_EN
        .fwd_addr_i(fwd_addr_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
`endif
        .ovf_o(ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [R_WIDTH-1:0] aa, input logic [WIDTH-1:0] ad,
                                input logic bv, input logic [R_WIDTH-1:0] ba, input logic [WIDTH-1:0] bd,
                                input logic er, input logic ef);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.bv = bv; v.ba = ba; v.bd = bd;
        v.expReady = er; v.expFull = ef;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endfunction

    task automatic modelReset();
        sb.delete();
        mqAddr.delete();
        mqData.delete();
        mStarve   = 0;
        mOvf      = 1'b0;
        mLastAddr = '0;
        mLastData = '0;
    endtask

    // Compares the registered outputs produced by the edge just taken.
    task automatic checkOutput(input logic expFull);
        wr_t w;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
        end else begin
            w = sb.pop_front();
            check("wr_en", {31'd0, wr_en_o}, {31'd0, w.en});
            check("wr_addr", {27'd0, wr_addr_o}, {27'd0, w.addr});
            check("wr_data", wr_data_o, w.data);
        end
        check("a_full", {31'd0, a_full_o}, {31'd0, expFull});
        check("ovf", {31'd0, ovf_o}, {31'd0, mOvf});
    endtask

    // Drives one cycle starting just after a rising edge and predicts its effect.
    task automatic applyStimulus(input vec_t v);
        logic empty, gb, ga;
        wr_t  w;
        a_valid_i = v.av; a_addr_i = v.aa; a_data_i = v.ad;
        b_valid_i = v.bv; b_addr_i = v.ba; b_data_i = v.bd;
        #1;
        check("b_ready", {31'd0, b_ready_o}, {31'd0, v.expReady});
        empty = (mqAddr.size() == 0);
        gb = v.bv && (v.ba != 0) && (empty || mStarve == STARVE_MAX);
        ga = !empty && !gb;
        w.en = gb || ga;
        w.addr = mLastAddr;
        w.data = mLastData;
        if (gb) begin
            w.addr = v.ba;
            w.data = v.bd;
        end else if (ga) begin
            w.addr = mqAddr.pop_front();
            w.data = mqData.pop_front();
        end
        mLastAddr = w.addr;
        mLastData = w.data;
        sb.push_back(w);
        if (v.av && v.aa != 0) begin
            if (mqAddr.size() < 2) begin
                mqAddr.push_back(v.aa);
                mqData.push_back(v.ad);
            end else begin
                mOvf = 1'b1;
            end
        end
        if (v.bv && v.ba != 0 && !gb) mStarve = (mStarve < STARVE_MAX) ? mStarve + 1 : STARVE_MAX;
        else mStarve = 0;
        @(posedge clk_i);
        #1;
        checkOutput(v.expFull);
    endtask

    initial begin
        rst_n_i = 1'b0;
        a_valid_i = 1'b0; a_addr_i = '0; a_data_i = '0;
        b_valid_i = 1'b0; b_addr_i = '0; b_data_i = '0;
`ifdef REGFILE_ARB_FWD_EN
        fwd_addr_i = '0;
`endif

        // Single A write, then lone B write, then r0 requests from both sides.
        vecs.push_back(idle());
        vecs.push_back(mk(1'b1, 5'd3, 32'h11, 1'b0, '0, '0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) vecs.push_back(idle());
        vecs.push_back(mk(1'b0, '0, '0, 1'b1, 5'd7, 32'hAB, 1'b1, 1'b0));
        vecs.push_back(idle());
        vecs.push_back(mk(1'b1, 5'd0, 32'h77, 1'b1, 5'd0, 32'h66, 1'b1, 1'b0));
        vecs.push_back(idle());
        vecs.push_back(idle());
        // A streams r1..r11 while B waits: r9 forced through, then r10 forced through into a full FIFO.
        vecs.push_back(mk(1'b1, 5'd1, 32'h101, 1'b0, '0, '0, 1'b0, 1'b0));
        for (int i = 2; i <= 5; i++)
            vecs.push_back(mk(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1, 5'd9, 32'hB9, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 5'd6, 32'h106, 1'b1, 5'd9, 32'hB9, 1'b1, 1'b1));
        for (int i = 7; i <= 10; i++)
            vecs.push_back(mk(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1, 5'd10, 32'hBA, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 5'd11, 32'h10B, 1'b1, 5'd10, 32'hBA, 1'b1, 1'b1));
        for (int i = 0; i < 3; i++) vecs.push_back(idle());

        #3;
        check("rst_wr_en", {31'd0, wr_en_o}, 32'd0);
        check("rst_wr_addr", {27'd0, wr_addr_o}, 32'd0);
        check("rst_wr_data", wr_data_o, 32'd0);
        check("rst_a_full", {31'd0, a_full_o}, 32'd0);
        check("rst_ovf", {31'd0, ovf_o}, 32'd0);
        check("rst_b_ready", {31'd0, b_ready_o}, 32'd0);
        #9;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

`ifdef REGFILE_ARB_FWD_EN
        applyStimulus(mk(1'b1, 5'd1, 32'h201, 1'b0, '0, '0, 1'b0, 1'b0));
        for (int i = 2; i <= 4; i++)
            applyStimulus(mk(1'b1, 5'(i), 32'h200 + 32'(i), 1'b1, 5'd9, 32'hC9, 1'b0, 1'b0));
        applyStimulus(mk(1'b1, 5'd5, 32'h1, 1'b1, 5'd9, 32'hC9, 1'b0, 1'b0));
        applyStimulus(mk(1'b1, 5'd5, 32'h2, 1'b1, 5'd9, 32'hC9, 1'b1, 1'b1));
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        fwd_addr_i = 5'd5;
        #1;
        check("fwd_hit_r5", {31'd0, fwd_hit_o}, 32'd1);
        check("fwd_data_r5", fwd_data_o, 32'h2);
        fwd_addr_i = 5'd9;
        #1;
        check("fwd_hit_r9", {31'd0, fwd_hit_o}, 32'd1);
        check("fwd_data_r9", fwd_data_o, 32'hC9);
        fwd_addr_i = 5'd0;
        #1;
        check("fwd_hit_r0", {31'd0, fwd_hit_o}, 32'd0);
        check("fwd_data_r0", fwd_data_o, 32'd0);
        fwd_addr_i = 5'd7;
        #1;
        check("fwd_hit_miss", {31'd0, fwd_hit_o}, 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(idle());
`endif

        // Reset while a write is on the port and another entry is buffered.
        applyStimulus(mk(1'b1, 5'd3, 32'h55, 1'b0, '0, '0, 1'b0, 1'b0));
        applyStimulus(mk(1'b1, 5'd4, 32'h66, 1'b0, '0, '0, 1'b0, 1'b0));
        a_valid_i = 1'b0;
        rst_n_i = 1'b0;
        #1;
        check("midrst_wr_en", {31'd0, wr_en_o}, 32'd0);
        check("midrst_wr_addr", {27'd0, wr_addr_o}, 32'd0);
        check("midrst_ovf", {31'd0, ovf_o}, 32'd0);
        check("midrst_a_full", {31'd0, a_full_o}, 32'd0);
        modelReset();
        #10;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 3; i++) applyStimulus(idle());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
